// File: rtl/sysid_regs_if.sv
// sysid_regs_if: Avalon-MM slave bundle for the system ID register block.
// The master drives address/strobes/data and the slave returns read data.
interface sysid_regs_if;
  logic [2:0]  address;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic [3:0]  byteenable;
  logic [31:0] readdata;
  logic        readdatavalid;

  modport master (
    output address, read, write,
    output writedata, byteenable,
    input  readdata, readdatavalid
  );

  modport slave (
    input  address, read, write,
    input  writedata, byteenable,
    output readdata, readdatavalid
  );
endinterface

// File: rtl/sysid_regs.sv
// sysid_regs: Avalon-MM system ID / scratch / uptime slave, 1-cycle reads.
// Define SYSID_UPTIME_EN to build the prescaler, 64-bit counter and snapshot.
module sysid_regs #(
  parameter logic [31:0] SYSTEM_ID    = 32'h524C_906B,
  parameter logic [31:0] TIMESTAMP    = 32'h4C8A_1F00,
  parameter logic [31:0] SCRATCH_INIT = 32'h0000_0000,
  parameter int unsigned PRESCALE     = 1,
  parameter logic [15:0] CAPS         = 16'h0001
) (
  input logic         clock,
  input logic         reset_n,
  sysid_regs_if.slave bus
);

  localparam bit PRE_OK =
    (PRESCALE >= 1) && (PRESCALE <= 65535);

  if (!PRE_OK) begin : g_bad_prescale
    $error("sysid_regs: PRESCALE out of range");
  end

  logic        rd;
  logic        wr;
  logic        wr_scr;
  logic        wr_ctl;
  logic [31:0] scratch_q, scratch_d;
  logic        freeze_q, freeze_d;
  logic [31:0] rdata_q, rdata_d;
  logic        rvalid_q, rvalid_d;
  logic [31:0] lo_w;
  logic [31:0] hi_w;
  logic        up_w;
  logic [31:0] rword;

  // a coincident read wins; the write is dropped
  assign rd     = bus.read;
  assign wr     = bus.write & ~bus.read;
  assign wr_scr = wr && (bus.address == 3'd4);
  assign wr_ctl = wr && (bus.address == 3'd5)
               && bus.byteenable[0];

`ifdef SYSID_UPTIME_EN
  localparam logic [15:0] PRE_TC =
    16'(PRESCALE - 1);

  logic        clear;
  logic [15:0] pre_q, pre_d;
  logic [63:0] cnt_q, cnt_d;
  logic [31:0] snap_q, snap_d;

  assign clear = wr_ctl && bus.writedata[0];

  always_comb begin
    pre_d  = pre_q;
    cnt_d  = cnt_q;
    snap_d = snap_q;
    if (rd && (bus.address == 3'd2))
      snap_d = cnt_q[63:32];
    if (clear) begin
      pre_d = '0;
      cnt_d = '0;
    end else if (!freeze_q) begin
      if (pre_q == PRE_TC) begin
        pre_d = '0;
        cnt_d = cnt_q + 64'd1;
      end else begin
        pre_d = pre_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pre_q  <= '0;
      cnt_q  <= '0;
      snap_q <= '0;
    end else begin
      pre_q  <= pre_d;
      cnt_q  <= cnt_d;
      snap_q <= snap_d;
    end
  end

  assign lo_w = cnt_q[31:0];
  assign hi_w = snap_q;
  assign up_w = 1'b1;
`else
  assign lo_w = '0;
  assign hi_w = '0;
  assign up_w = 1'b0;
`endif

  always_comb begin
    rword = '0;
    unique case (bus.address)
      3'd0:    rword = SYSTEM_ID;
      3'd1:    rword = TIMESTAMP;
      3'd2:    rword = lo_w;
      3'd3:    rword = hi_w;
      3'd4:    rword = scratch_q;
      3'd5:    rword = {30'd0, freeze_q, 1'b0};
      3'd6:    rword = {15'd0, up_w, CAPS};
      default: rword = '0;
    endcase
  end

  always_comb begin
    scratch_d = scratch_q;
    for (int i = 0; i < 4; i++) begin
      if (wr_scr && bus.byteenable[i])
        scratch_d[8*i +: 8] = bus.writedata[8*i +: 8];
    end
    freeze_d = wr_ctl ? bus.writedata[1] : freeze_q;
    rvalid_d = rd;
    rdata_d  = rd ? rword : rdata_q;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      scratch_q <= SCRATCH_INIT;
      freeze_q  <= 1'b0;
      rdata_q   <= '0;
      rvalid_q  <= 1'b0;
    end else begin
      scratch_q <= scratch_d;
      freeze_q  <= freeze_d;
      rdata_q   <= rdata_d;
      rvalid_q  <= rvalid_d;
    end
  end

  assign bus.readdata      = rdata_q;
  assign bus.readdatavalid = rvalid_q;

endmodule

// File: tb/tb_sysid_regs.sv
// tb_sysid_regs: random + directed bench for sysid_regs with a cycle model.
// Builds with or without SYSID_UPTIME_EN; PRESCALE is fixed at 4 here.
module tb_sysid_regs;

  localparam int          P     = 4;
  localparam logic [31:0] SID   = 32'h524C_906B;
  localparam logic [31:0] TS    = 32'h4C8A_1F00;
  localparam logic [31:0] SINIT = 32'h1357_9BDF;
  localparam logic [15:0] CP    = 16'h0001;
`ifdef SYSID_UPTIME_EN
  localparam bit UP = 1'b1;
`else
  localparam bit UP = 1'b0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  sysid_regs_if bif();

  sysid_regs #(
    .SYSTEM_ID(SID),
    .TIMESTAMP(TS),
    .SCRATCH_INIT(SINIT),
    .PRESCALE(P),
    .CAPS(CP)
  ) dut (
    .clock(clk),
    .reset_n(rst_n),
    .bus(bif)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(string n, logic [63:0] a,
                     logic [63:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", n, a, e);
    end
  endtask

  // reference model: register contents as plain values
  logic [31:0] m_scr;
  logic        m_frz;
  logic [63:0] m_cnt;
  int          m_pre;
  logic [31:0] m_snap;
  logic        m_valid = 1'b0;
  logic [31:0] m_data  = '0;
  logic        chk_en  = 1'b0;
  logic        bd_load = 1'b0;
  logic [63:0] bd_val  = '0;

  function automatic logic [31:0] mread(logic [2:0] a);
    case (a)
      3'd0:    return SID;
      3'd1:    return TS;
      3'd2:    return UP ? m_cnt[31:0] : 32'd0;
      3'd3:    return m_snap;
      3'd4:    return m_scr;
      3'd5:    return {30'd0, m_frz, 1'b0};
      3'd6:    return {15'd0, UP, CP};
      default: return 32'd0;
    endcase
  endfunction

  task automatic mreset();
    m_scr   = SINIT;
    m_frz   = 1'b0;
    m_cnt   = '0;
    m_pre   = 0;
    m_snap  = '0;
    m_valid = 1'b0;
    m_data  = '0;
  endtask

  task automatic mstep();
    logic       r, w, clr, nf;
    logic [2:0] a;
    if (bd_load) m_cnt = bd_val;
    r = bif.read;
    w = bif.write && !r;
    a = bif.address;
    m_valid = r;
    if (r) m_data = mread(a);
    if (r && a == 3'd2 && UP) m_snap = m_cnt[63:32];
    clr = 1'b0;
    nf  = m_frz;
    if (w && a == 3'd4)
      for (int i = 0; i < 4; i++)
        if (bif.byteenable[i])
          m_scr[8*i +: 8] = bif.writedata[8*i +: 8];
    if (w && a == 3'd5 && bif.byteenable[0]) begin
      clr = bif.writedata[0];
      nf  = bif.writedata[1];
    end
    if (UP) begin
      if (clr) begin
        m_cnt = '0;
        m_pre = 0;
      end else if (!m_frz) begin
        m_pre++;
        if (m_pre == P) begin
          m_pre = 0;
          m_cnt = m_cnt + 64'd1;
        end
      end
    end
    m_frz = nf;
  endtask

  initial begin
    mreset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) mreset();
      else mstep();
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        chk("rvalid", bif.readdatavalid, m_valid);
        chk("rdata", bif.readdata, m_data);
      end
    end
  end

  task automatic drv(logic r, logic w, logic [2:0] a,
                     logic [31:0] d, logic [3:0] be);
    @(negedge clk);
    bif.read       = r;
    bif.write      = w;
    bif.address    = a;
    bif.writedata  = d;
    bif.byteenable = be;
    @(posedge clk);
    #1;
    bif.read  = 1'b0;
    bif.write = 1'b0;
  endtask

  task automatic do_rd(input logic [2:0] a,
                       output logic [31:0] q);
    drv(1'b1, 1'b0, a, 32'd0, 4'd0);
    q = bif.readdata;
  endtask

  task automatic do_wr(logic [2:0] a, logic [31:0] d,
                       logic [3:0] be);
    drv(1'b0, 1'b1, a, d, be);
  endtask

  task automatic do_idle(int n);
    repeat (n) drv(1'b0, 1'b0, 3'd0, 32'd0, 4'd0);
  endtask

  logic [31:0] q, lo, hi;
  int          n1;
  logic        found;

  initial begin
    bif.read       = 1'b0;
    bif.write      = 1'b0;
    bif.address    = '0;
    bif.writedata  = '0;
    bif.byteenable = '0;
    #1 rst_n = 1'b0;
    #20;
    chk("rst_rvalid", bif.readdatavalid, 1'b0);
    chk("rst_rdata", bif.readdata, 32'd0);
    @(negedge clk);
    rst_n  = 1'b1;
    chk_en = 1'b1;

    do_rd(3'd0, q); chk("id", q, 32'h524C_906B);
    do_rd(3'd1, q); chk("ts", q, 32'h4C8A_1F00);
    do_rd(3'd6, q);
`ifdef SYSID_UPTIME_EN
    chk("caps", q, 32'h0001_0001);
`else
    chk("caps", q, 32'h0000_0001);
`endif
    do_rd(3'd7, q); chk("rsvd", q, 32'd0);

    do_rd(3'd4, q); chk("scr_init", q, 32'h1357_9BDF);
    do_wr(3'd4, 32'hDEAD_BEEF, 4'b1111);
    do_wr(3'd4, 32'h0000_1234, 4'b0011);
    do_rd(3'd4, q); chk("scr_be", q, 32'hDEAD_1234);
    drv(1'b1, 1'b1, 3'd4, 32'hFFFF_FFFF, 4'b1111);
    chk("rdwr_old", bif.readdata, 32'hDEAD_1234);
    do_rd(3'd4, q); chk("rdwr_keep", q, 32'hDEAD_1234);
    do_wr(3'd7, 32'hFFFF_FFFF, 4'b1111);
    do_rd(3'd7, q); chk("rsvd_wr", q, 32'd0);

    do_wr(3'd5, 32'd2, 4'b0001);
    do_rd(3'd5, q); chk("ctl_frz", q, 32'd2);
    do_wr(3'd5, 32'd0, 4'b0001);

`ifndef SYSID_UPTIME_EN
    do_rd(3'd2, q); chk("lo_off", q, 32'd0);
    do_rd(3'd3, q); chk("hi_off", q, 32'd0);
`else
    do_wr(3'd5, 32'd1, 4'b0001);
    do_idle(40);
    do_rd(3'd2, q); chk("pre40", q, 32'd10);
    do_wr(3'd5, 32'd2, 4'b0001);
    do_rd(3'd2, q); chk("frz_a", q, 32'd10);
    do_idle(20);
    do_rd(3'd2, q); chk("frz_b", q, 32'd10);

    do_wr(3'd5, 32'd0, 4'b0001);
    found = 1'b0;
    for (int i = 0; i < 8 && !found; i++) begin
      if (m_pre == P - 1) found = 1'b1;
      else do_idle(1);
    end
    chk("pre_wait", found, 1'b1);
    do_wr(3'd5, 32'd1, 4'b0001);
    do_rd(3'd2, q); chk("clr_prio", q, 32'd0);
    do_rd(3'd5, q); chk("ctl_rd0", q, 32'd0);

    do_wr(3'd5, 32'd3, 4'b0001);
    force dut.cnt_q = 64'h0000_0000_FFFF_FFFF;
    bd_val  = 64'h0000_0000_FFFF_FFFF;
    bd_load = 1'b1;
    do_idle(1);
    bd_load = 1'b0;
    release dut.cnt_q;
    do_wr(3'd5, 32'd0, 4'b0001);
    n1 = 0;
    for (int i = 0; i < 6; i++) begin
      do_rd(3'd2, lo);
      do_rd(3'd3, hi);
      chk("hi_vs_lo", hi,
          (lo >= 32'h8000_0000) ? 32'd0 : 32'd1);
      if (hi == 32'd1) n1++;
    end
    chk("wrap_seen", (n1 > 0), 1'b1);
`endif

    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 3))
        0: do_idle(1);
        1: drv(1'b1, 1'b0, 3'($urandom()), 32'd0, 4'd0);
        2: drv(1'b0, 1'b1, 3'($urandom()),
               $urandom(), 4'($urandom()));
        default: drv(1'b1, 1'b1, 3'($urandom()),
                     $urandom(), 4'($urandom()));
      endcase
    end

    do_wr(3'd4, 32'hCAFE_F00D, 4'b1111);
    do_rd(3'd4, q); chk("pre_arst", q, 32'hCAFE_F00D);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_rvalid", bif.readdatavalid, 1'b0);
    chk("arst_rdata", bif.readdata, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    do_rd(3'd4, q); chk("arst_scr", q, 32'h1357_9BDF);
    do_rd(3'd5, q); chk("arst_ctl", q, 32'd0);
    do_idle(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sysid_regs.md
Name: sysid_regs

Overview:
- Parametrised successor to the fixed two-word system-ID slave: an Avalon-MM control slave holding a small register file.
- Register file contents:
  - system ID, build timestamp, a capabilities word
  - read/write scratch register
  - free-running 64-bit uptime counter with a coherent snapshot
  - control register
- Software uses it to identify the hardware build and to measure elapsed time.
- Sits on the system interconnect next to the CPU, with a fixed read latency of 1 cycle.

Parameters:
- SYSTEM_ID, 32'h524C_906B, value returned at word 0
- TIMESTAMP, 32'h4C8A_1F00, build timestamp returned at word 1
- SCRATCH_INIT, 32'h0000_0000, reset value of the scratch register
- PRESCALE, 1, clocks per uptime increment; legal range 1..65535
- CAPS, 16'h0001, user capability bits reported in CAPS[15:0]

Ports:
- clock  in  1  single system clock; all logic is rising-edge
- reset_n  in  1  reset, asynchronous assert and active-low
- address  in  3  word address
- read  in  1  read strobe, one cycle per transfer
- write  in  1  write strobe, one cycle per transfer
- writedata  in  32  write data
- byteenable  in  4  byte lanes for writes; bit n covers writedata[8n+7:8n]
- readdata  out  32  registered read data
- readdatavalid  out  1  high for exactly one cycle, one clock after an accepted read

Behaviour:
- Register map (word address):
  - 0 ID: RO, SYSTEM_ID
  - 1 TIMESTAMP: RO, TIMESTAMP
  - 2 UPTIME_LO: RO, counter[31:0]
  - 3 UPTIME_HI: RO, returns the snapshot
  - 4 SCRATCH: RW, honours byteenable
  - 5 CONTROL: RW
    - bit0 CLEAR: write-1, self-clearing, always reads 0
    - bit1 FREEZE: level; other bits read 0
  - 6 CAPS: RO
    - [15:0] CAPS
    - [16] uptime present
    - [31:17] 0
  - 7: reserved, reads 0, writes ignored
- Reset values:
  - readdata 0, readdatavalid 0
  - scratch SCRATCH_INIT
  - FREEZE 0
  - counter, snapshot and prescaler all 0
- Read timing:
  - A read sampled at edge N loads readdata at edge N.
  - readdatavalid is high from edge N to edge N+1.
  - Reads are accepted every cycle, so back-to-back reads give back-to-back readdatavalid.
  - readdata holds its last value when no read is in progress.
- Writes:
  - Take effect on the sampling edge; no wait states.
  - Lanes with byteenable=0 are unchanged.
  - Writes to RO words or word 7 are ignored.
- read and write in the same cycle: the read is serviced and the write is discarded.
- Prescaler:
  - Counts 0..PRESCALE-1 while FREEZE=0.
  - On terminal count it wraps to 0 and the counter increments by 1.
  - With PRESCALE=1 the counter increments every cycle.
- Counter:
  - 64-bit, wraps from 2^64-1 to 0 with no flag.
  - FREEZE=1 holds both the prescaler and the counter.
- Coherent read:
  - A read of UPTIME_LO returns counter[31:0] and, in the same edge, latches counter[63:32] into the snapshot.
  - UPTIME_HI returns the snapshot, never the live value.
- CLEAR:
  - Zeros the counter and prescaler on the write edge.
  - Takes priority over a coincident increment.
  - Does not alter the snapshot.
  - CLEAR and FREEZE may be written together; both take effect.
- Reset mid-operation: all state returns to reset values immediately, independent of clock; readdatavalid drops asynchronously.

Optional Feature:
- Macro: SYSID_UPTIME_EN.
- When defined:
  - Prescaler, counter and snapshot logic are present as described.
  - CAPS[16]=1.
- When undefined:
  - No counter, prescaler or snapshot flops are built.
  - Words 2 and 3 read 0.
  - CONTROL CLEAR and FREEZE are accepted but have no effect; FREEZE still reads back.
  - CAPS[16]=0.
  - All other behaviour is unchanged.

Test Plan:
- Release reset, read words 0, 1, 6 back-to-back -> readdatavalid high 3 consecutive cycles with readdata 32'h524C_906B, 32'h4C8A_1F00, 32'h0001_0001 (uptime enabled).
- Write SCRATCH 32'hDEAD_BEEF with byteenable 4'b1111, then 32'h0000_1234 with byteenable 4'b0011, read -> 32'hDEAD_1234; simultaneous read+write of 32'hFFFF_FFFF returns the old value and scratch stays unchanged.
- Cross the 32-bit boundary:
  - Set FREEZE and force the counter to 64'h0000_0000_FFFF_FFFF (via backdoor or clear-then-count), release FREEZE.
  - Read LO as the counter wraps, then read HI.
  - Required: the {HI, LO} pair equals one sampled counter value; HI never mismatches LO.
- PRESCALE=4: clear, run 40 cycles, read UPTIME_LO -> 10 (±1 per exact sample edge); set FREEZE for 20 cycles -> value unchanged.
- Write CONTROL bit0 on the same edge as a scheduled increment -> counter reads 0 afterwards; CONTROL reads 0.
- Assert reset_n low mid-read -> readdatavalid and readdata drop to 0 without a clock edge; scratch returns to SCRATCH_INIT.
